ysyx_220066_mem_arbiter: RTL and testbench
==========================================

Name: ysyx_220066_mem_arbiter

Overview:
- Shares one 64-bit memory bus between the instruction-fetch port (IF stage) and the data port (M stage) of the ysyx_220066 core.
- Sequences one outstanding bus transaction at a time: arbitrate, address phase, response phase, acknowledge.
- Returns fetch words and load data to the requesting stage and provides the stall/valid signals the pipeline blocks on.

Parameters:
- STARVE_LIMIT, 4: consecutive D grants allowed while I is waiting (used only with the optional feature).
- ADDR_W, 64: address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  fetch request; level, held until i_ack
- i_addr  in  ADDR_W  fetch address, 4-byte aligned
- i_flush  in  1  redirect; discard any pending fetch
- i_ack  out  1  one-cycle pulse: i_rdata/i_err valid
- i_rdata  out  32  fetched instruction
- i_err  out  1  fetch bus error
- d_rd  in  1  load request; level, held until d_ack
- d_wr  in  1  store request; level, held until d_ack
- d_addr  in  ADDR_W  data address
- d_wdata  in  64  store data
- d_wmask  in  8  byte mask
- d_len  in  3  access length code
- d_ack  out  1  one-cycle pulse: d_rdata/d_err valid
- d_rdata  out  64  load data, raw 64-bit beat
- d_err  out  1  data bus error
- bus_req  out  1  address-phase valid
- bus_we  out  1  write
- bus_addr  out  ADDR_W
- bus_wdata  out  64
- bus_wmask  out  8
- bus_len  out  3
- bus_gnt  in  1  address phase accepted
- bus_rvalid  in  1  response valid
- bus_rdata  in  64
- bus_err  in  1
- busy  out  1  state not IDLE

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low.
- Reset: all outputs 0; state IDLE; owner and flush-discard flag cleared. Assertion mid-transaction drops bus_req immediately. The downstream bus must be reset with the arbiter.
- FSM states: IDLE, ADDR, WAIT, RESP.
- IDLE:
  - If d_rd or d_wr is set, owner=D.
  - Else if i_req and not i_flush, owner=I.
  - On a grant, latch the owner's fields into output registers and go to ADDR. Otherwise stay in IDLE.
- ADDR:
  - bus_req=1; fields stay stable.
  - bus_gnt=1 goes to WAIT.
- WAIT:
  - bus_rvalid=1 latches bus_rdata/bus_err and goes to RESP.
  - bus_rvalid is never sampled in ADDR; the bus returns it at the earliest one cycle after gnt.
- RESP:
  - Pulse the owner's ack for exactly one cycle, then go to IDLE.
  - No arbitration in RESP, so the requester sees its ack before its level request is re-sampled.
- Minimum latency, request to ack: 3 cycles (IDLE sample, ADDR with immediate gnt, WAIT with rvalid next, RESP).
- Fetch data: i_rdata = bus_addr[2] ? rdata[63:32] : rdata[31:0]. The selection uses the latched address.
- Data path: d_rdata is the raw 64-bit beat. Sign/zero extension is done in WB.
- Store: d_wr with d_rd also high counts as a write. bus_we=1 and d_rdata is don't-care.
- Flush:
  - i_flush while owner=I in ADDR or WAIT sets the discard flag. The transaction completes on the bus, i_ack is suppressed in RESP, and the flag clears.
  - i_flush in IDLE blocks I grant that cycle.
  - i_flush never affects D.
- Simultaneous events:
  - d request and i_req both present in IDLE: D wins.
  - Flush in the same cycle as rvalid: response discarded.
- i_err/d_err are valid only with their ack and are 0 otherwise.
- busy = (state != IDLE).

Optional Feature:
- Macro: YSYX_220066_ARB_STARVE_EN.
- Enabled:
  - A saturating counter counts D grants made while i_req is set and i_flush is clear.
  - When the counter equals STARVE_LIMIT, the next IDLE arbitration grants I even if D is requesting.
  - The counter clears on any I grant, or when i_req is low in IDLE.
- Disabled: strict D priority; no counter flops.

Decomposition:
- Package ysyx_220066_arb_pkg holds:
  - state encoding enum: IDLE=2'd0, ADDR=2'd1, WAIT=2'd2, RESP=2'd3;
  - owner constants OWN_I=1'b0, OWN_D=1'b1.
- Sub-module ysyx_220066_arb_starve holds the starvation counter and the force_i output. It is instantiated only under the macro.

Test Plan:
- Fetch i_req, i_addr=0x80000004; gnt immediate, rvalid next cycle with rdata=0x11112222_33334444 -> i_ack at cycle 3, i_rdata=0x11112222, i_err=0.
- d_wr and i_req in the same cycle; d_addr=0x80001000, wmask=0x0F -> bus_we=1 with D fields first, d_ack, then the I transaction starts 1 cycle after RESP.
- I in WAIT, i_flush pulsed, then rvalid -> no i_ack; FSM back to IDLE; the next i_req at a new address is granted normally.
- bus_gnt held low 5 cycles -> bus_req and all fields stable for 5 cycles; bus_err=1 with rvalid -> d_ack with d_err=1.
- rst_n low while in WAIT -> bus_req=0, busy=0, no ack, immediately (asynchronous).
- Macro on, STARVE_LIMIT=4, D requests back-to-back with i_req held -> 4 D grants, then 1 I grant.

Source files
------------

// File: rtl/ysyx_220066_arb_pkg.sv
// Shared definitions for the ysyx_220066 memory arbiter.
//   arb_state_e : bus-sequencing FSM encoding
//   OWN_I/OWN_D : which port owns the current bus transaction
//   LEN_FETCH   : length code driven for instruction fetches (one 32-bit word)
//   fetch_word  : picks the addressed 32-bit half of a 64-bit beat
package ysyx_220066_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } arb_state_e;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam logic [2:0] LEN_FETCH = 3'd2;

  function automatic logic [31:0] fetch_word(input logic hi, input logic [63:0] beat);
    return hi ? beat[63:32] : beat[31:0];
  endfunction

endpackage

// File: rtl/ysyx_220066_arb_starve.sv
// Starvation guard for the fetch port of the memory arbiter.
// Counts D grants made while a fetch is waiting (i_req set, i_flush clear),
// saturating at STARVE_LIMIT. force_i asks the arbiter to grant I at the next
// IDLE arbitration once the limit is reached.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   arb_idle   : arbiter FSM is in IDLE
//   i_req      : fetch request level
//   i_flush    : fetch redirect
//   grant_d    : D port granted this cycle
//   grant_i    : I port granted this cycle
//   force_i    : limit reached, I must win next arbitration
module ysyx_220066_arb_starve #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arb_idle,
  input  logic i_req,
  input  logic i_flush,
  input  logic grant_d,
  input  logic grant_i,
  output logic force_i
);

  localparam int unsigned CntW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (grant_i || (arb_idle && !i_req)) begin
      cnt_d = '0;
    end else if (grant_d && i_req && !i_flush && (cnt_q != Limit)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_i = (cnt_q == Limit);

endmodule

// File: rtl/ysyx_220066_mem_arbiter.sv
// Shares one 64-bit memory bus between the IF fetch port (I) and the M-stage
// data port (D). One transaction is outstanding at a time:
// IDLE (arbitrate) -> ADDR (bus_req until bus_gnt) -> WAIT (until bus_rvalid)
// -> RESP (one-cycle ack to the owner) -> IDLE.
// D has priority over I. Define YSYX_220066_ARB_STARVE_EN to add a starvation
// guard that grants I after STARVE_LIMIT consecutive D grants made while I waits.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   i_req/i_addr/i_flush            : fetch request, address, redirect
//   i_ack/i_rdata/i_err             : fetch completion pulse, word, bus error
//   d_rd/d_wr/d_addr/d_wdata/
//   d_wmask/d_len                   : load/store request and fields
//   d_ack/d_rdata/d_err             : data completion pulse, raw beat, bus error
//   bus_req/bus_we/bus_addr/
//   bus_wdata/bus_wmask/bus_len     : address phase towards memory
//   bus_gnt                         : address phase accepted
//   bus_rvalid/bus_rdata/bus_err    : response phase from memory
//   busy                            : FSM not in IDLE
module ysyx_220066_mem_arbiter
  import ysyx_220066_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned ADDR_W       = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_flush,
  output logic              i_ack,
  output logic [31:0]       i_rdata,
  output logic              i_err,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [63:0]       d_wdata,
  input  logic [7:0]        d_wmask,
  input  logic [2:0]        d_len,
  output logic              d_ack,
  output logic [63:0]       d_rdata,
  output logic              d_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [63:0]       bus_wdata,
  output logic [7:0]        bus_wmask,
  output logic [2:0]        bus_len,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [63:0]       bus_rdata,
  input  logic              bus_err,
  output logic              busy
);

  arb_state_e state_q, state_d;

  logic              owner_q;
  logic              discard_q, discard_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [63:0]       wdata_q;
  logic [7:0]        wmask_q;
  logic [2:0]        len_q;
  logic [63:0]       rdata_q;
  logic              err_q;

  logic arb_idle;
  logic d_want;
  logic i_want;
  logic force_i;
  logic grant_i;
  logic grant_d;

  assign arb_idle = (state_q == IDLE);
  assign d_want   = d_rd | d_wr;
  // A flush in IDLE blocks the fetch grant for that cycle.
  assign i_want   = i_req & ~i_flush;

`ifdef YSYX_220066_ARB_STARVE_EN
  ysyx_220066_arb_starve #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk     (clk),
    .rst_n   (rst_n),
    .arb_idle(arb_idle),
    .i_req   (i_req),
    .i_flush (i_flush),
    .grant_d (grant_d),
    .grant_i (grant_i),
    .force_i (force_i)
  );
`else
  assign force_i = 1'b0;
`endif

  // D wins unless the starvation guard is forcing a fetch that can be taken.
  assign grant_i = arb_idle & i_want & (~d_want | force_i);
  assign grant_d = arb_idle & d_want & ~grant_i;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    unique case (state_q)
      IDLE: begin
        discard_d = 1'b0;
        if (grant_i || grant_d) begin
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (owner_q == OWN_I && i_flush) begin
          discard_d = 1'b1;
        end
        if (bus_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Flush coinciding with rvalid still discards the response.
        if (owner_q == OWN_I && i_flush) begin
          discard_d = 1'b1;
        end
        if (bus_rvalid) begin
          state_d = RESP;
        end
      end
      RESP: begin
        discard_d = 1'b0;
        state_d   = IDLE;
      end
      default: begin
        discard_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // Transaction fields and response capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q   <= OWN_I;
      discard_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      len_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      discard_q <= discard_d;
      if (grant_d) begin
        owner_q <= OWN_D;
        we_q    <= d_wr;
        addr_q  <= d_addr;
        wdata_q <= d_wdata;
        wmask_q <= d_wmask;
        len_q   <= d_len;
      end else if (grant_i) begin
        owner_q <= OWN_I;
        we_q    <= 1'b0;
        addr_q  <= i_addr;
        wdata_q <= '0;
        wmask_q <= '0;
        len_q   <= LEN_FETCH;
      end
      if (state_q == WAIT && bus_rvalid) begin
        rdata_q <= bus_rdata;
        err_q   <= bus_err;
      end
    end
  end

  // Outputs
  always_comb begin
    bus_req   = (state_q == ADDR);
    bus_we    = we_q;
    bus_addr  = addr_q;
    bus_wdata = wdata_q;
    bus_wmask = wmask_q;
    bus_len   = len_q;
    busy      = (state_q != IDLE);
    i_ack     = (state_q == RESP) && (owner_q == OWN_I) && !discard_q;
    d_ack     = (state_q == RESP) && (owner_q == OWN_D);
    i_err     = i_ack & err_q;
    d_err     = d_ack & err_q;
    i_rdata   = fetch_word(addr_q[2], rdata_q);
    d_rdata   = rdata_q;
  end

endmodule

// File: tb/tb_ysyx_220066_mem_arbiter.sv
module tb_ysyx_220066_mem_arbiter;

  localparam int unsigned ADDR_W       = 64;
  localparam int unsigned STARVE_LIMIT = 4;
`ifdef YSYX_220066_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  logic              clk, rst_n;
  logic              i_req, i_flush, i_ack, i_err;
  logic [ADDR_W-1:0] i_addr;
  logic [31:0]       i_rdata;
  logic              d_rd, d_wr, d_ack, d_err;
  logic [ADDR_W-1:0] d_addr;
  logic [63:0]       d_wdata, d_rdata;
  logic [7:0]        d_wmask;
  logic [2:0]        d_len;
  logic              bus_req, bus_we, bus_gnt, bus_rvalid, bus_err, busy;
  logic [ADDR_W-1:0] bus_addr;
  logic [63:0]       bus_wdata, bus_rdata;
  logic [7:0]        bus_wmask;
  logic [2:0]        bus_len;

  ysyx_220066_mem_arbiter #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .ADDR_W      (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_flush   (i_flush),
    .i_ack     (i_ack),
    .i_rdata   (i_rdata),
    .i_err     (i_err),
    .d_rd      (d_rd),
    .d_wr      (d_wr),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_wmask   (d_wmask),
    .d_len     (d_len),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .d_err     (d_err),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_wmask (bus_wmask),
    .bus_len   (bus_len),
    .bus_gnt   (bus_gnt),
    .bus_rvalid(bus_rvalid),
    .bus_rdata (bus_rdata),
    .bus_err   (bus_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          own_d;
    bit          rd;
    bit          we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [2:0]  len;
  } txn_t;

  typedef struct {
    bit          own_d;
    bit          we;
    logic [63:0] data;
    bit          err;
  } resp_t;

  txn_t  exp_txn_q[$];
  resp_t exp_resp_q[$];

  int total = 0;
  int bad   = 0;

  // Bus-model knobs; negative means randomize.
  int          force_gwait = -1;
  int          force_rwait = -1;
  int          force_err   = -1;
  bit          force_rdata_en = 1'b0;
  logic [63:0] force_rdata = '0;
  bit          exp_discard = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Bus responder + monitor (all at negedge, away from the active edge)
  // ---------------------------------------------------------------------------
  int    phase = 0, gwait = 0, rwait = 0, req_cycles = 0;
  int    pend = 0;  // 0 none, 1 I ack due, 2 D ack due, 3 I response discarded
  bit    req_prev = 1'b0, cur_valid = 1'b0;
  txn_t  cur;
  resp_t r;

  always @(negedge clk) begin : bus_mon
    if (!rst_n) begin
      phase = 0; pend = 0; req_prev = 1'b0; cur_valid = 1'b0;
      bus_gnt = 1'b0; bus_rvalid = 1'b0;
    end else begin
      // response side
      check("i_err_without_ack", {63'b0, i_err & ~i_ack}, 64'd0);
      check("d_err_without_ack", {63'b0, d_err & ~d_ack}, 64'd0);
      if (pend == 0) begin
        check("spurious_ack", {62'b0, i_ack, d_ack}, 64'd0);
      end else begin
        check("i_ack_timing", {63'b0, i_ack}, {63'b0, pend == 1});
        check("d_ack_timing", {63'b0, d_ack}, {63'b0, pend == 2});
        if (pend != 3) begin
          if (exp_resp_q.size() == 0) begin
            check("resp_queue_underflow", 64'd1, 64'd0);
          end else begin
            r = exp_resp_q.pop_front();
            if (i_ack && !r.own_d) begin
              check("i_rdata", {32'b0, i_rdata}, r.data);
              check("i_err", {63'b0, i_err}, {63'b0, r.err});
            end
            if (d_ack && r.own_d) begin
              if (!r.we) check("d_rdata", d_rdata, r.data);
              check("d_err", {63'b0, d_err}, {63'b0, r.err});
            end
          end
        end
      end
      pend = 0;

      // address-phase side
      if (bus_req) begin
        if (!req_prev) begin
          if (exp_txn_q.size() == 0) begin
            check("unexpected_bus_req", 64'd1, 64'd0);
            cur_valid = 1'b0;
          end else begin
            cur = exp_txn_q.pop_front();
            cur_valid = 1'b1;
          end
          req_cycles = 0;
        end
        req_cycles++;
        if (cur_valid) begin
          check("bus_we", {63'b0, bus_we}, {63'b0, cur.we});
          check("bus_addr", bus_addr, cur.addr);
          check("bus_wmask", {56'b0, bus_wmask}, {56'b0, cur.wmask});
          if (cur.own_d) begin
            check("bus_wdata", bus_wdata, cur.wdata);
            check("bus_len", {61'b0, bus_len}, {61'b0, cur.len});
          end
        end
      end
      req_prev = bus_req;

      // responder
      bus_gnt = 1'b0;
      bus_rvalid = 1'b0;
      if (phase == 0 && bus_req) begin
        phase = 1;
        gwait = (force_gwait >= 0) ? force_gwait : $urandom_range(0, 3);
      end
      if (phase == 1) begin
        if (gwait == 0) begin
          bus_gnt = 1'b1;
          phase = 2;
          rwait = (force_rwait >= 0) ? force_rwait : $urandom_range(0, 2);
          if (force_gwait >= 0) check("gnt_hold_cycles", 64'(req_cycles), 64'(force_gwait + 1));
        end else begin
          gwait--;
        end
      end else if (phase == 2) begin
        if (rwait == 0) begin
          bus_rvalid = 1'b1;
          bus_rdata = force_rdata_en ? force_rdata : {$urandom, $urandom};
          bus_err = (force_err >= 0) ? force_err[0] : ($urandom_range(0, 7) == 0);
          phase = 0;
          if (!cur.own_d && exp_discard) begin
            pend = 3;
            exp_discard = 1'b0;
          end else begin
            r.own_d = cur.own_d;
            r.we    = cur.we;
            r.err   = bus_err;
            if (cur.own_d) r.data = bus_rdata;
            else r.data = cur.addr[2] ? {32'b0, bus_rdata[63:32]} : {32'b0, bus_rdata[31:0]};
            exp_resp_q.push_back(r);
            pend = cur.own_d ? 2 : 1;
          end
        end else begin
          rwait--;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  function automatic txn_t rand_d(input int kind);
    txn_t t;
    t.own_d = 1'b1;
    t.rd    = kind[0];
    t.we    = kind[1];
    t.addr  = {$urandom, $urandom};
    t.wdata = {$urandom, $urandom};
    t.wmask = 8'($urandom);
    t.len   = 3'($urandom_range(0, 7));
    return t;
  endfunction

  function automatic txn_t mk_i(input logic [63:0] addr);
    txn_t t;
    t.own_d = 1'b0;
    t.rd    = 1'b0;
    t.we    = 1'b0;
    t.addr  = addr;
    t.wdata = '0;
    t.wmask = '0;
    t.len   = '0;
    return t;
  endfunction

  task automatic drive_d(input txn_t t);
    d_rd = t.rd; d_wr = t.we; d_addr = t.addr;
    d_wdata = t.wdata; d_wmask = t.wmask; d_len = t.len;
  endtask

  task automatic drive_i(input txn_t t);
    i_req = 1'b1; i_addr = t.addr;
  endtask

  task automatic wait_d_ack(input int limit);
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (d_ack) return;
    end
    check("d_ack_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_i_ack(input int limit);
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (i_ack) return;
    end
    check("i_ack_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!busy) return;
    end
    check("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_gnt();
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      if (bus_gnt) return;
    end
    check("gnt_timeout", 64'd1, 64'd0);
  endtask

  task automatic knobs_default();
    force_gwait = -1; force_rwait = -1; force_err = -1; force_rdata_en = 1'b0;
  endtask

  // D (kind: 1 rd, 2 wr, 3 rd+wr) and/or I raised in the same cycle; D goes first.
  task automatic run_round(input int dkind, input bit ion);
    txn_t dt, it;
    dt = rand_d(dkind);
    it = mk_i({$urandom, $urandom} & ~64'h3);
    @(negedge clk);
    if (dkind != 0) begin exp_txn_q.push_back(dt); drive_d(dt); end
    if (ion) begin exp_txn_q.push_back(it); drive_i(it); end
    fork
      begin
        if (dkind != 0) begin wait_d_ack(200); d_rd = 1'b0; d_wr = 1'b0; end
      end
      begin
        if (ion) begin wait_i_ack(200); i_req = 1'b0; end
      end
    join
    wait_idle();
  endtask

  // when: 0 flush in ADDR, 1 flush in WAIT, 2 flush together with rvalid
  task automatic flush_case(input int when);
    txn_t it;
    it = mk_i({$urandom, $urandom} & ~64'h3);
    force_gwait = 2; force_rwait = 2;
    exp_discard = 1'b1;
    @(negedge clk);
    exp_txn_q.push_back(it);
    drive_i(it);
    if (when == 0) begin
      @(negedge clk);
    end else begin
      wait_gnt();
      @(negedge clk);
      if (when == 2) repeat (2) @(negedge clk);
    end
    i_flush = 1'b1; i_req = 1'b0;
    @(negedge clk);
    i_flush = 1'b0;
    wait_idle();
    check("discard_consumed", {63'b0, exp_discard}, 64'd0);
    exp_discard = 1'b0;
    knobs_default();
    run_round(0, 1'b1);
  endtask

  // n back-to-back D requests with a fetch held throughout.
  task automatic burst(input int n);
    txn_t dt[$];
    txn_t it;
    int   cnt, dleft, di;
    bit   iwait;
    for (int k = 0; k < n; k++) dt.push_back(rand_d($urandom_range(1, 3)));
    it = mk_i({$urandom, $urandom} & ~64'h3);
    // Reference order: D first, unless LIMIT D grants already went by while I waited.
    cnt = 0; dleft = n; di = 0; iwait = 1'b1;
    while (dleft > 0 || iwait) begin
      if (dleft > 0 && !(STARVE_EN && iwait && cnt == STARVE_LIMIT)) begin
        exp_txn_q.push_back(dt[di]);
        di++; dleft--;
        if (iwait && cnt < STARVE_LIMIT) cnt++;
      end else begin
        exp_txn_q.push_back(it);
        iwait = 1'b0; cnt = 0;
      end
    end
    @(negedge clk);
    drive_d(dt[0]);
    drive_i(it);
    fork
      begin
        for (int k = 0; k < n; k++) begin
          wait_d_ack(200);
          if (k < n - 1) drive_d(dt[k+1]);
          else begin d_rd = 1'b0; d_wr = 1'b0; end
        end
      end
      begin
        wait_i_ack(600);
        i_req = 1'b0;
      end
    join
    wait_idle();
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int cnt;
    txn_t dt, it;
    rst_n = 1'b0;
    i_req = 1'b0; i_addr = '0; i_flush = 1'b0;
    d_rd = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0; d_wmask = '0; d_len = '0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0; bus_err = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    @(negedge clk);
    check("rst_bus_req", {63'b0, bus_req}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_acks", {62'b0, i_ack, d_ack}, 64'd0);
    check("rst_bus_addr", bus_addr, 64'd0);
    check("rst_bus_we", {63'b0, bus_we}, 64'd0);
    check("rst_d_rdata", d_rdata, 64'd0);

    // Fetch with immediate gnt and next-cycle rvalid: ack three cycles after request.
    force_gwait = 0; force_rwait = 0; force_err = 0;
    force_rdata_en = 1'b1; force_rdata = 64'h11112222_33334444;
    it = mk_i(64'h8000_0004);
    exp_txn_q.push_back(it);
    drive_i(it);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      cnt++;
      if (i_ack) break;
    end
    check("fetch_latency", 64'(cnt), 64'd3);
    check("fetch_rdata_hi", {32'b0, i_rdata}, 64'h1111_2222);
    check("fetch_err", {63'b0, i_err}, 64'd0);
    i_req = 1'b0;
    wait_idle();
    knobs_default();

    // Store and fetch together: D first, I address phase one cycle after RESP.
    dt = rand_d(2);
    dt.addr = 64'h8000_1000; dt.wmask = 8'h0F;
    it = mk_i(64'h8000_2008);
    @(negedge clk);
    exp_txn_q.push_back(dt); exp_txn_q.push_back(it);
    drive_d(dt); drive_i(it);
    wait_d_ack(200);
    d_wr = 1'b0;
    @(negedge clk);
    check("idle_after_resp", {63'b0, busy}, 64'd0);
    @(negedge clk);
    check("i_addr_phase_after_d", {63'b0, bus_req}, 64'd1);
    wait_i_ack(200);
    i_req = 1'b0;
    wait_idle();

    // Flush discards a pending fetch in ADDR, in WAIT, and together with rvalid.
    for (int w = 0; w < 3; w++) flush_case(w);

    // Flush in IDLE blocks the fetch grant.
    it = mk_i(64'h8000_3000);
    @(negedge clk);
    exp_txn_q.push_back(it);
    i_flush = 1'b1;
    drive_i(it);
    repeat (2) begin
      @(negedge clk);
      check("idle_flush_blocks", {63'b0, busy}, 64'd0);
    end
    i_flush = 1'b0;
    wait_i_ack(200);
    i_req = 1'b0;
    wait_idle();

    // Flush never touches a D transaction.
    force_rwait = 2;
    dt = rand_d(1);
    @(negedge clk);
    exp_txn_q.push_back(dt);
    drive_d(dt);
    wait_gnt();
    @(negedge clk) i_flush = 1'b1;
    @(negedge clk) i_flush = 1'b0;
    wait_d_ack(200);
    d_rd = 1'b0;
    wait_idle();
    knobs_default();

    // Grant held off 5 cycles, error response on a load.
    force_gwait = 5; force_err = 1;
    run_round(1, 1'b0);
    knobs_default();

    // Randomized rounds.
    for (int k = 0; k < 30; k++) begin
      int dk;
      bit io;
      dk = $urandom_range(0, 3);
      io = (dk == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      run_round(dk, io);
    end

    // Back-to-back D with fetch waiting.
    burst(6);

    // Asynchronous reset while in WAIT.
    force_gwait = 0; force_rwait = 8;
    dt = rand_d(1);
    @(negedge clk);
    exp_txn_q.push_back(dt);
    drive_d(dt);
    wait_gnt();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_bus_req", {63'b0, bus_req}, 64'd0);
    check("async_rst_busy", {63'b0, busy}, 64'd0);
    check("async_rst_acks", {62'b0, i_ack, d_ack}, 64'd0);
    d_rd = 1'b0;
    exp_resp_q.delete();
    exp_txn_q.delete();
    knobs_default();
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", {63'b0, busy}, 64'd0);

    for (int k = 0; k < 5; k++) run_round($urandom_range(1, 3), 1'b1);

    repeat (3) @(negedge clk);
    check("txn_queue_drained", 64'(exp_txn_q.size()), 64'd0);
    check("resp_queue_drained", 64'(exp_resp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
